// File: rtl/button_debounce.sv
// button_debounce: synchronise and debounce WIDTH buttons (PCLK, RESET_n, BUTTON_IN, INT_ACK in; BUTTON_OUT, PRESS, RELEASE, CHANGED, INT_REQ out)
module button_debounce #(
  parameter int WIDTH = 8,
  parameter int PRESCALE = 1000,
  parameter int STABLE_TICKS = 4,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b1}}
) (
  input  logic             PCLK,
  input  logic             RESET_n,
  input  logic [WIDTH-1:0] BUTTON_IN,
  input  logic             INT_ACK,
  output logic [WIDTH-1:0] BUTTON_OUT,
  output logic [WIDTH-1:0] PRESS,
  output logic [WIDTH-1:0] RELEASE,
  output logic [WIDTH-1:0] CHANGED,
  output logic             INT_REQ
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);
  logic [WIDTH-1:0] sync1_q, sync2_q, out_q, out_d, press_q, press_d, release_q, release_d, changed_q, changed_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic tick;
  always_comb begin
    tick = presc_q == P_LAST;
    presc_d = tick ? '0 : presc_q + PW'(1);
    cnt_d = cnt_q;
    out_d = out_q;
    press_d = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (tick) begin
        cnt_d[i] = (sync2_q[i] == out_q[i] || cnt_q[i] == C_LAST) ? '0 : cnt_q[i] + CW'(1);
        if (sync2_q[i] != out_q[i] && cnt_q[i] == C_LAST) begin
          out_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
          release_d[i] = !sync2_q[i];
        end
      end
    end
    changed_d = (INT_ACK ? '0 : changed_q) | press_q | release_q;
  end
  always_ff @(posedge PCLK) begin
    if (!RESET_n) begin
      sync1_q <= INIT;
      sync2_q <= INIT;
      out_q <= INIT;
      press_q <= '0;
      release_q <= '0;
      changed_q <= '0;
      presc_q <= '0;
      cnt_q <= '0;
    end else begin
      sync1_q <= BUTTON_IN;
      sync2_q <= sync1_q;
      out_q <= out_d;
      press_q <= press_d;
      release_q <= release_d;
      changed_q <= changed_d;
      presc_q <= presc_d;
      cnt_q <= cnt_d;
    end
  end
  assign BUTTON_OUT = out_q;
  assign PRESS = press_q;
  assign RELEASE = release_q;
  assign CHANGED = changed_q;
  assign INT_REQ = |changed_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: scoreboard bench for button_debounce (PRESCALE=4, STABLE_TICKS=3)
module tb_button_debounce;
  logic PCLK = 1'b0;
  logic RESET_n;
  logic [7:0] BUTTON_IN;
  logic INT_ACK;
  logic [7:0] BUTTON_OUT, PRESS, RELEASE, CHANGED;
  logic INT_REQ;
  typedef struct {
    logic [7:0] pr;
    logic [7:0] rl;
    logic [7:0] bo;
    logic [7:0] ch;
  } ev_t;
  ev_t q[$];
  ev_t e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ev_cyc = 0;
  int r;
  bit pend = 0;
  logic [7:0] pend_ch;
  button_debounce #(.WIDTH(8), .PRESCALE(4), .STABLE_TICKS(3), .INIT(8'hFF)) dut (
    .PCLK(PCLK), .RESET_n(RESET_n), .BUTTON_IN(BUTTON_IN), .INT_ACK(INT_ACK),
    .BUTTON_OUT(BUTTON_OUT), .PRESS(PRESS), .RELEASE(RELEASE), .CHANGED(CHANGED), .INT_REQ(INT_REQ)
  );
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;
  function automatic void check(string n, logic [31:0] a, logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endfunction
  always @(negedge PCLK) begin
    if (pend) begin
      check("pulse_width", {24'd0, PRESS | RELEASE}, 32'h0);
      check("changed", {24'd0, CHANGED}, {24'd0, pend_ch});
      check("int_req", {31'd0, INT_REQ}, {31'd0, |pend_ch});
      pend = 0;
    end
    if (RESET_n && (PRESS | RELEASE) != 8'h00) begin
      ev_cyc = cyc;
      if (q.size() == 0) check("unexpected_event", {16'd0, PRESS, RELEASE}, 32'h0);
      else begin
        e = q.pop_front();
        check("press", {24'd0, PRESS}, {24'd0, e.pr});
        check("release", {24'd0, RELEASE}, {24'd0, e.rl});
        check("button_out", {24'd0, BUTTON_OUT}, {24'd0, e.bo});
        pend = 1;
        pend_ch = e.ch;
      end
    end
  end
  task automatic wait_idle(input int lim);
    int n = 0;
    while ((q.size() != 0 || pend) && n < lim) begin
      @(negedge PCLK);
      n++;
    end
    if (q.size() != 0 || pend) begin
      check("event_timeout", 32'(q.size()), 32'h0);
      q.delete();
      pend = 0;
    end
    repeat (4) @(negedge PCLK);
  endtask
  task automatic ack_clear();
    INT_ACK = 1'b1;
    @(negedge PCLK);
    INT_ACK = 1'b0;
    check("ack_changed", {24'd0, CHANGED}, 32'h0);
    check("ack_int_req", {31'd0, INT_REQ}, 32'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    RESET_n = 1'b0;
    BUTTON_IN = 8'h00;
    INT_ACK = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_button_out", {24'd0, BUTTON_OUT}, 32'hFF);
    check("rst_press", {24'd0, PRESS}, 32'h0);
    check("rst_release", {24'd0, RELEASE}, 32'h0);
    check("rst_changed", {24'd0, CHANGED}, 32'h0);
    check("rst_int_req", {31'd0, INT_REQ}, 32'h0);
    r = cyc;
    RESET_n = 1'b1;
    BUTTON_IN = 8'hFE;
    q.push_back('{8'h00, 8'h01, 8'hFE, 8'h01});
    wait_idle(40);
    check("press_latency", 32'(ev_cyc - r), 32'd12);
    for (int k = 0; k < 12; k++) begin
      BUTTON_IN[3] = ~BUTTON_IN[3];
      repeat (5) @(negedge PCLK);
    end
    repeat (20) @(negedge PCLK);
    check("bounce_button_out", {24'd0, BUTTON_OUT}, 32'hFE);
    check("bounce_changed", {24'd0, CHANGED}, 32'h01);
    BUTTON_IN[5] = 1'b0;
    q.push_back('{8'h00, 8'h20, 8'hDE, 8'h20});
    begin
      int n = 0;
      while (!RELEASE[5] && n < 40) begin
        @(negedge PCLK);
        n++;
      end
      if (RELEASE[5]) begin
        INT_ACK = 1'b1;
        @(negedge PCLK);
        INT_ACK = 1'b0;
      end
    end
    wait_idle(40);
    ack_clear();
    BUTTON_IN = 8'hFF;
    q.push_back('{8'h21, 8'h00, 8'hFF, 8'h21});
    wait_idle(40);
    ack_clear();
    BUTTON_IN = 8'h0F;
    q.push_back('{8'h00, 8'hF0, 8'h0F, 8'hF0});
    wait_idle(40);
    BUTTON_IN = 8'hFF;
    q.push_back('{8'hF0, 8'h00, 8'hFF, 8'hF0});
    wait_idle(40);
    ack_clear();
    RESET_n = 1'b0;
    @(negedge PCLK);
    RESET_n = 1'b1;
    BUTTON_IN = 8'hFD;
    repeat (9) @(negedge PCLK);
    RESET_n = 1'b0;
    @(negedge PCLK);
    r = cyc;
    RESET_n = 1'b1;
    check("midrst_button_out", {24'd0, BUTTON_OUT}, 32'hFF);
    q.push_back('{8'h00, 8'h02, 8'hFD, 8'h02});
    wait_idle(40);
    check("midrst_latency", 32'(ev_cyc - r), 32'd12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
